// File: rtl/pwm.sv
// Fixed-frequency PWM generator: period counter, period-aligned duty shadow
// register and a registered compare output.
module pwm #(
    parameter int unsigned CLK_FREQ = 1_000_000,
    parameter int unsigned PWM_FREQ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty,
    output logic       pwm_out
);

    localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned PROD_W = 8 + $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [PROD_W-1:0] PERIOD_EXT = PROD_W'(PERIOD);

    generate
        if (PERIOD < 2) begin : g_bad_period
            $error("pwm: CLK_FREQ / PWM_FREQ must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        duty_q, duty_d;
    logic              pwm_q, pwm_d;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] thresh;

    // Shadow duty only changes at the period boundary so a period is never split.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        duty_d = duty_q;
        prod   = PROD_W'(duty_q) * PERIOD_EXT;
        thresh = prod >> 8;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            duty_d = duty;
        end
        pwm_d = (PROD_W'(cnt_q) < thresh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm.sv
// Bench for pwm: period-level reference (high count per period from the duty
// present at the previous period's last edge) with directed and random duty.
module tb_pwm;

    localparam int P  = 1000;
    localparam int P4 = 4;

    logic       clk;
    logic       rst;
    logic [7:0] duty;
    logic [7:0] duty4;
    logic       pwm_out;
    logic       pwm_out4;

    int n_cmp;
    int n_bad;
    int shadow_m;

    pwm u_dut (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty),
        .pwm_out (pwm_out)
    );

    pwm #(.CLK_FREQ(8), .PWM_FREQ(2)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty4),
        .pwm_out (pwm_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // High cycles per period: duty/256 of the period, truncated.
    function automatic int ref_hi(input int d, input int p);
        return (d * p) / 256;
    endfunction

    // One full output period; optional duty change after sample chg_at.
    task automatic run_period(input string tag, input logic [7:0] d_start,
                              input int chg_at, input logic [7:0] d_chg);
        int exp_hi;
        int hi;
        int shadow_next;
        int first;
        bit fell;
        bit shape_ok;
        exp_hi      = ref_hi(shadow_m, P);
        hi          = 0;
        fell        = 1'b0;
        shape_ok    = 1'b1;
        first       = 0;
        shadow_next = shadow_m;
        duty        = d_start;
        for (int i = 0; i < P; i++) begin
            if (i == P - 1) shadow_next = int'(duty);
            @(posedge clk);
            #1;
            if (i == 0) first = int'(pwm_out);
            if (pwm_out) begin
                hi++;
                if (fell) shape_ok = 1'b0;
            end else begin
                fell = 1'b1;
            end
            if (i == P - 1) check({tag, "_cnt_wrap"}, int'(u_dut.cnt_q), 0);
            if (i == chg_at) duty = d_chg;
        end
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_shape"}, int'(shape_ok), 1);
        check({tag, "_first"}, first, (exp_hi > 0) ? 1 : 0);
        shadow_m = shadow_next;
    endtask

    initial begin
        logic [7:0] dtab [5];
        int hi;
        int k;
        dtab[0] = 8'd0;
        dtab[1] = 8'd64;
        dtab[2] = 8'd128;
        dtab[3] = 8'd200;
        dtab[4] = 8'd255;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        duty     = 8'd0;
        duty4    = 8'd128;
        shadow_m = 0;

        // Reset: output and counter held at zero.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_out", int'(pwm_out), 0);
            check("rst_cnt", int'(u_dut.cnt_q), 0);
        end
        rst = 1'b0;

        // First period after reset runs at duty 0 regardless of applied duty.
        run_period("p0_dut64", 8'd64, -1, 8'd0);
        run_period("p1_dut64", 8'd64, -1, 8'd0);
        run_period("p2_dut128", 8'd128, -1, 8'd0);
        run_period("p3_dut200", 8'd200, -1, 8'd0);
        run_period("p4_dut255", 8'd255, -1, 8'd0);
        run_period("p5_dut255", 8'd64, -1, 8'd0);
        run_period("p6_chg", 8'd64, 100, 8'd200);
        run_period("p7_after_chg", 8'd0, -1, 8'd0);
        run_period("p8_zero", 8'd0, -1, 8'd0);

        // Randomized duty with occasional mid-period changes.
        for (int r = 0; r < 10; r++) begin
            logic [7:0] d0;
            logic [7:0] d1;
            int ca;
            d0 = ($urandom_range(0, 1) == 0) ? dtab[$urandom_range(0, 4)]
                                              : 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            ca = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, P - 2));
            run_period($sformatf("rnd%0d", r), d0, ca, d1);
        end

        // Mid-period reset with shadow 128.
        run_period("pre_rst_a", 8'd128, -1, 8'd0);
        run_period("pre_rst_b", 8'd128, -1, 8'd0);
        hi = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (pwm_out) hi++;
        end
        check("mid_rst_hi400", hi, 400);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out", int'(pwm_out), 0);
        check("mid_rst_cnt", int'(u_dut.cnt_q), 0);
        rst      = 1'b0;
        shadow_m = 0;
        run_period("post_rst_p0", 8'd128, -1, 8'd0);
        run_period("post_rst_p1", 8'd128, -1, 8'd0);

        // Period-4 instance: one low period after reset, then 1,1,0,0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("p4_rst_out", int'(pwm_out4), 0);
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 16; i++) begin
            int e;
            @(posedge clk);
            #1;
            e = (k < P4) ? 0 : (((k % P4) < ref_hi(128, P4)) ? 1 : 0);
            check($sformatf("p4_pat%0d", k), int'(pwm_out4), e);
            k++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
